// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment sequencer.
// Contents: RISC-V load/store funct3 encodings, the sequencer state type,
// the access-size helper and the legality helper used during decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } lsu_state_e;

    // Access size in bytes; 0 marks an encoding that is not a load/store size.
    function automatic logic [2:0] size_of(input logic [2:0] func3);
        logic [2:0] size;
        case (func3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd0;
        endcase
        return size;
    endfunction

    // Stores only exist as sb/sh/sw; the unsigned encodings are load-only.
    function automatic logic legal_op(input logic is_store, input logic [2:0] func3);
        logic legal;
        if (is_store) begin
            legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
        end else begin
            legal = (size_of(func3) != 3'd0);
        end
        return legal;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension.
// Ports:
//   i_func3 : funct3 of the load, selects width and signedness
//   i_raw   : raw little-endian load data, valid bytes in the low lanes
//   o_data  : sign- or zero-extended 32-bit result
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    // Select the extension rule from the load width and signedness.
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_func3)
            F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_W:    o_data = i_raw;
            F3_BU:   o_data = {24'h00_0000, i_raw[7:0]};
            F3_HU:   o_data = {16'h0000, i_raw[15:0]};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_align_sequencer.sv
// Load/store sequencer sitting between EX/MEM and a single-port byte memory.
// Aligned accesses are forwarded combinationally; misaligned lw/lh/lhu/sw/sh
// are replayed as one byte access per cycle while the pipeline is stalled.
// All load data is extended here because the memory returns narrow loads
// zero-padded.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   req_*            : request from EX/MEM (read, write, funct3, addr, wdata)
//   stall            : freeze PC, IF/ID, ID/EX, EX/MEM
//   resp_valid/rdata : extended load result to MEM/WB (rdata is 0 when idle)
//   mem_*            : memory request and combinational read data
module lsu_align_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    logic [1:0]        r_idx;
    logic              r_read;
    logic              r_write;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [23:0]       r_buf;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_active;
    logic              w_misaligned;
    logic              w_start_split;
    logic              w_last;
    logic [2:0]        w_req_size;
    logic [2:0]        w_lat_size;
    logic [7:0]        w_store_byte;
    logic [31:0]       w_assembled;
    logic [31:0]       w_raw;
    logic [2:0]        w_ext_func3;
    logic [31:0]       w_ext;

    // A simultaneous read+write is a store; the read is dropped.
    assign w_is_store    = req_write;
    assign w_is_load     = req_read & ~req_write;
    assign w_active      = (w_is_store | w_is_load) & legal_op(w_is_store, req_func3);
    assign w_req_size    = size_of(req_func3);
    assign w_misaligned  = ((w_req_size == 3'd2) & req_addr[0]) |
                           ((w_req_size == 3'd4) & (req_addr[1:0] != 2'b00));
    assign w_start_split = SPLIT_EN & w_active & w_misaligned;

    // In SPLIT the latched funct3 is always a legal 2- or 4-byte access.
    assign w_lat_size = size_of(r_func3);
    assign w_last     = ({1'b0, r_idx} == (w_lat_size - 3'd1));

    // Pick the store byte for the current split index.
    always_comb begin
        w_store_byte = 8'h00;
        case (r_idx)
            2'd0:    w_store_byte = r_wdata[7:0];
            2'd1:    w_store_byte = r_wdata[15:8];
            2'd2:    w_store_byte = r_wdata[23:16];
            2'd3:    w_store_byte = r_wdata[31:24];
            default: w_store_byte = 8'h00;
        endcase
    end

    // Merge the byte arriving now with the bytes gathered so far; unused
    // upper lanes are zero because the buffer is cleared at split start.
    always_comb begin
        w_assembled = {8'h00, r_buf};
        case (r_idx)
            2'd1:    w_assembled[15:8]  = mem_rdata[7:0];
            2'd2:    w_assembled[23:16] = mem_rdata[7:0];
            2'd3:    w_assembled[31:24] = mem_rdata[7:0];
            default: w_assembled = {8'h00, r_buf};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_split) begin
                    w_state_next = SPLIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SPLIT: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SPLIT;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Latched request, byte index and load byte buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_func3 <= 3'b000;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
            r_buf   <= 24'h00_0000;
        end else if (r_state == IDLE) begin
            if (w_start_split) begin
                r_read  <= w_is_load;
                r_write <= w_is_store;
                r_func3 <= req_func3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_buf   <= {16'h0000, mem_rdata[7:0]};
                r_idx   <= 2'd1;
            end else begin
                r_idx   <= 2'd0;
            end
        end else begin
            if (r_read) begin
                case (r_idx)
                    2'd1:    r_buf[15:8]  <= mem_rdata[7:0];
                    2'd2:    r_buf[23:16] <= mem_rdata[7:0];
                    default: r_buf        <= r_buf;
                endcase
            end else begin
                r_buf <= r_buf;
            end
            if (w_last) begin
                r_idx <= 2'd0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Output decode: reset forces an idle memory port, so a reset landing
    // mid-split writes nothing further.
    always_comb begin
        stall       = 1'b0;
        resp_valid  = 1'b0;
        mem_addr    = req_addr;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_func3   = req_func3;
        mem_wdata   = req_wdata;
        w_raw       = mem_rdata;
        w_ext_func3 = req_func3;
        if (rst) begin
            stall = 1'b0;
        end else if (r_state == SPLIT) begin
            mem_addr    = r_addr + ADDR_W'(r_idx);
            mem_read    = r_read;
            mem_write   = r_write;
            mem_func3   = r_write ? F3_B : F3_BU;
            mem_wdata   = {24'h00_0000, w_store_byte};
            w_raw       = w_assembled;
            w_ext_func3 = r_func3;
            stall       = ~w_last;
            resp_valid  = w_last & r_read;
        end else if (w_start_split) begin
            mem_read  = w_is_load;
            mem_write = w_is_store;
            mem_func3 = w_is_store ? F3_B : F3_BU;
            mem_wdata = {24'h00_0000, req_wdata[7:0]};
            stall     = 1'b1;
        end else if (w_active) begin
            mem_read   = w_is_load;
            mem_write  = w_is_store;
            resp_valid = w_is_load;
        end else begin
            stall = 1'b0;
        end
    end

    load_extend u_load_extend (
        .i_func3 (w_ext_func3),
        .i_raw   (w_raw),
        .o_data  (w_ext)
    );

    assign resp_rdata = resp_valid ? w_ext : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_align_sequencer.sv
// Directed bench for lsu_align_sequencer: a 64-byte memory model answers the
// DUT's memory port, a transaction-level reference predicts every cycle.
module tb_lsu_align_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;

    always #5 clk = ~clk;

    lsu_align_sequencer #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- memory attached to the DUT ----------------
    logic [7:0] mem [0:63];
    logic [7:0] ref_mem [0:63];
    logic       load_init;
    logic [5:0] rd_a;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'h11;
            4:       return 8'h09;
            8:       return 8'h19;
            17:      return 8'hE1;
            18:      return 8'hF5;
            19:      return 8'h05;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
                mem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    assign rd_a = mem_addr[5:0];
    always_comb begin
        mem_rdata = {24'h0, mem[rd_a]};
        if (mem_func3[1:0] == 2'b01)
            mem_rdata = {16'h0, mem[rd_a + 6'd1], mem[rd_a]};
        else if (mem_func3[1:0] == 2'b10)
            mem_rdata = {mem[rd_a + 6'd3], mem[rd_a + 6'd2], mem[rd_a + 6'd1], mem[rd_a]};
    end

    // ---------------- checking ----------------
    int          n_vec = 0, n_fail = 0, n_stall = 0;
    logic [31:0] last_resp;
    logic        chk_en = 1'b0;
    logic        e_stall, e_rv, e_rd, e_wr;
    logic [31:0] e_rdata, e_addr, e_wdata, e_wmask;
    logic [2:0]  e_f3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("mem_write", 32'(mem_write), 32'(e_wr));
            if (e_rd || e_wr) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_func3", 32'(mem_func3), 32'(e_f3));
            end
            if (e_wr) chk("mem_wdata", mem_wdata & e_wmask, e_wdata & e_wmask);
            if (stall) n_stall++;
            if (resp_valid) last_resp = resp_rdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_n(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Little-endian gather of the N bytes from the reference memory, then
    // sign handling by plain arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] u;
        logic [5:0]  ix;
        int          n;
        n = size_n(f3);
        u = 32'd0;
        for (int i = 0; i < n; i++) begin
            ix = 6'(addr + 32'(i));
            u  = u + 32'(ref_mem[ix]) * (32'd1 << (8 * i));
        end
        if (f3 == 3'b000 && u >= 32'd128)   u = u - 32'd256;
        if (f3 == 3'b001 && u >= 32'd32768) u = u - 32'd65536;
        return u;
    endfunction

    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input int rst_at);
        logic        store, load, legal, mis;
        logic [31:0] resp, sh;
        int          n, ncyc;
        store = wr;
        load  = rd && !wr;
        n     = size_n(f3);
        legal = store ? (f3 inside {3'b000, 3'b001, 3'b010})
                      : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (!(store || load)) legal = 1'b0;
        mis = 1'b0;
        if (legal) mis = (addr % 32'(n)) != 32'd0;
        resp = (load && legal) ? model_load(f3, addr) : 32'd0;
        ncyc = mis ? n : 1;
        req_read = rd; req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        for (int k = 0; k < ncyc; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                e_stall = 1'b0; e_rv = 1'b0; e_rdata = 32'd0; e_rd = 1'b0; e_wr = 1'b0;
                chk_en = 1'b1;
                @(negedge clk); @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            e_stall = mis && (k < n - 1);
            e_rv    = load && legal && (k == ncyc - 1);
            e_rdata = e_rv ? resp : 32'd0;
            e_rd    = load && legal;
            e_wr    = store && legal;
            if (mis) begin
                e_addr = addr + 32'(k); e_f3 = store ? 3'b000 : 3'b100;
                e_wdata = wdata >> (8 * k); e_wmask = 32'h0000_00FF;
            end else begin
                e_addr = addr; e_f3 = f3; e_wdata = wdata; e_wmask = 32'hFFFF_FFFF;
            end
            chk_en = 1'b1;
            @(negedge clk); @(posedge clk); #1;
            if (e_wr) begin
                if (mis) begin
                    ref_mem[6'(addr + 32'(k))] = e_wdata[7:0];
                end else begin
                    for (int i = 0; i < n; i++) begin
                        sh = wdata >> (8 * i);
                        ref_mem[6'(addr + 32'(i))] = sh[7:0];
                    end
                end
            end
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    // Load with a literal expectation on the captured result and stall count.
    task automatic lit_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp, input int exp_stalls);
        int s0;
        s0 = n_stall;
        last_resp = 32'hBAD0_BAD0;
        run_txn(1'b1, 1'b0, f3, addr, 32'd0, -1);
        chk(nm, last_resp, exp);
        chk({nm, "_stalls"}, 32'(n_stall - s0), 32'(exp_stalls));
    endtask

    initial begin
        int s0;
        rst = 1'b1; load_init = 1'b1;
        req_read = 1'b1; req_write = 1'b0; req_func3 = 3'b010;
        req_addr = 32'h0000_1234; req_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_byte(i);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0000_1234);
        chk("rst_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; load_init = 1'b0; req_read = 1'b0;

        lit_load("lw0", 3'b010, 32'd0, 32'h0000_0011, 0);
        lit_load("lw1", 3'b010, 32'd1, 32'h0900_0000, 3);
        lit_load("lh16", 3'b001, 32'd16, 32'hFFFF_E100, 0);
        lit_load("lhu16", 3'b101, 32'd16, 32'h0000_E100, 0);
        lit_load("lb17", 3'b000, 32'd17, 32'hFFFF_FFE1, 0);

        s0 = n_stall;
        run_txn(1'b0, 1'b1, 3'b001, 32'd5, 32'h1234_ABCD, -1);
        chk("sh5_stalls", 32'(n_stall - s0), 32'd1);
        lit_load("lw4", 3'b010, 32'd4, 32'h00AB_CD09, 0);

        run_txn(1'b0, 1'b1, 3'b010, 32'd3, 32'hAABB_CCDD, 1);
        run_txn(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, -1);
        chk("abort_b3", 32'(mem[3]), 32'h0000_00DD);
        chk("abort_b4", 32'(mem[4]), 32'h0000_0009);
        chk("abort_b5", 32'(mem[5]), 32'h0000_00CD);
        chk("abort_b6", 32'(mem[6]), 32'h0000_00AB);

        s0 = n_stall;
        run_txn(1'b1, 1'b0, 3'b011, 32'd1, 32'd0, -1);
        chk("f3_011_stalls", 32'(n_stall - s0), 32'd0);
        run_txn(1'b1, 1'b1, 3'b010, 32'd8, 32'hCAFE_F00D, -1);
        lit_load("lw8", 3'b010, 32'd8, 32'hCAFE_F00D, 0);

        lit_load("lh17", 3'b001, 32'd17, 32'hFFFF_F5E1, 1);
        lit_load("lhu19", 3'b101, 32'd19, 32'h0000_0005, 1);
        lit_load("lw_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_1100, 3);
        run_txn(1'b0, 1'b1, 3'b110, 32'd12, 32'h5555_5555, -1);
        run_txn(1'b0, 1'b1, 3'b100, 32'd12, 32'h6666_6666, -1);
        lit_load("lbu18", 3'b100, 32'd18, 32'h0000_00F5, 0);
        run_txn(1'b0, 1'b1, 3'b010, 32'd62, 32'h0102_0304, -1);
        lit_load("lw62", 3'b010, 32'd62, 32'h0102_0304, 3);
        chk("nostore_b12", 32'(mem[12]), 32'h0000_0000);

        chk_en = 1'b0;
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_align_sequencer.md
Name: lsu_align_sequencer

Overview:
- Load/store sequencer between the EX/MEM pipeline register and the unified single-port byte-addressed memory, on the data-phase side of that memory.
- Aligned accesses pass straight through with zero added latency.
- Misaligned lw/lh/lhu/sw/sh are split into one byte access per cycle, and the pipeline is stalled until the access completes.
- Sign/zero-extends all load data. The memory returns byte and half loads zero-padded, so every sign-extending load depends on this block.

Parameters:
- ADDR_W, 32, address width; byte addresses wrap modulo 2^ADDR_W.
- SPLIT_EN, 1, 1 = split misaligned accesses; 0 = forward every access unchanged (no stall, memory behaviour undefined for misaligned).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_read  in  1  load request (MemRead from EX/MEM)
- req_write  in  1  store request (MemWrite from EX/MEM)
- req_func3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- resp_valid  out  1  resp_rdata valid this cycle (loads only)
- resp_rdata  out  32  extended load data, to MEM/WB
- mem_addr  out  ADDR_W  to memory addr
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_func3  out  3  to memory func3
- mem_wdata  out  32  to memory readData2
- mem_rdata  in  32  from memory data_out (combinational, data phase)

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values: state=IDLE, idx=0, byte buffer=0.
  - stall=0, resp_valid=0, mem_read=0, mem_write=0.
  - mem_addr, mem_func3, mem_wdata are driven from the req_* inputs.
- States: IDLE, SPLIT. 2-bit byte index idx. Latched request registers: read, write, func3, addr, wdata, buf[23:0].
- Legal func3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other func3, or a store with func3 bit 2 set, is a no-op: mem_read=0, mem_write=0, resp_valid=0, stall=0.
- req_read and req_write both high: treated as a store; read ignored; resp_valid=0.
- Size N: 1 for b/bu, 2 for h/hu, 4 for w.
- Misaligned means:
  - N=2 and addr[0]=1, or
  - N=4 and addr[1:0]≠0.
- IDLE, aligned (or SPLIT_EN=0):
  - mem_* = req_*, combinationally.
  - Load: resp_valid=1 in the same cycle; resp_rdata = extend(mem_rdata).
  - stall=0. Stay in IDLE.
- IDLE, misaligned:
  - Issue byte 0 in the same cycle: mem_addr=addr; mem_func3=100 for loads, 000 for stores; mem_wdata[7:0]=wdata[7:0].
  - stall=1. Latch the request and byte 0. idx←1. Go to SPLIT.
- SPLIT:
  - Issue byte idx from the latched request: mem_addr = addr+idx (mod 2^ADDR_W); store byte = wdata[8·idx+7:8·idx].
  - Load: capture mem_rdata[7:0] into buf byte idx.
  - If idx<N-1: stall=1, idx←idx+1.
  - If idx=N-1:
    - stall=0 (pipeline advances at this edge).
    - Load: resp_valid=1; resp_rdata = extend({mem_rdata[7:0], buf}), truncated to N bytes.
    - Next state IDLE, idx←0.
- Latency: misaligned access takes N cycles with N-1 stall cycles; the memory sees exactly N byte accesses.
- The req_* inputs are ignored while in SPLIT. The pipeline holds them stable by construction.
- Extension:
  - lb: sign-extend bit 7. lh: sign-extend bit 15.
  - lbu, lhu: zero-extend.
  - lw: unchanged.
- rst during SPLIT: return to IDLE at the edge. No further bytes are written. Bytes already stored remain. No response is produced.
- resp_rdata = 0 whenever resp_valid=0.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, SPLIT).
  - size_of(func3) function.
- One sub-module, load_extend: combinational extension of a 32-bit raw value by func3.

Test Plan:
- Data region preloaded: word@0=17, @4=9, @8=25, @16=0x05F5E100.
- lw addr 0 → resp_valid same cycle, rdata=0x00000011, stall never asserted.
- lw addr 1 → stall high for 3 cycles; byte reads at 1,2,3,4; rdata=0x09000000 in cycle 4.
- lh addr 16 → 0xFFFFE100. lhu addr 16 → 0x0000E100. lb addr 17 → 0xFFFFFFE1. All single-cycle.
- sh addr 5, wdata=0x1234ABCD → 2 byte writes (5←CD, 6←AB), 1 stall cycle; subsequent lw addr 4 → 0x00ABCD09.
- sw addr 3, wdata=0xAABBCCDD, rst asserted in the 2nd cycle → state IDLE next cycle; only byte 3 (0xDD) written; bytes 4–6 unchanged; stall=0.
- func3=011 with req_read=1 → no memory access, resp_valid=0, stall=0. req_read=req_write=1, sw addr 8 → treated as a store, resp_valid=0.
